uart_edge_sync: RTL and testbench
=================================

// Module: uart_edge_sync
// PURPOSE
//  Multi-channel async-input conditioner for the SCI/UART block: synchronises N
//  asynchronous lines, glitch-filters each, and emits per-channel one-cycle edge
//  pulses (rise/fall/both/off selectable at run time). Generalised successor to the
//  single-stage rising-edge enable detector; feeds SCI control/IRQ logic.
// PARAMETERS
//  N            1   number of channels
//  SYNC_STAGES  2   synchroniser depth, legal 2..4
//  FILTER       1   consecutive identical synced samples needed to accept a new level, legal 1..15 (1 = no filtering)
// PORTS
//  iCLOCK       in   1    system clock, rising edge
//  inRESET      in   1    asynchronous active-low reset
//  iRESET_SYNC  in   1    synchronous clear, active-high, same effect as reset
//  iSIGNAL      in   N    asynchronous input lines
//  iMODE        in   2N   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  iEVENT_CLR   in   N    sticky event clear, one bit per channel
//  oLEVEL       out  N    filtered, synchronised level
//  oEDGE        out  N    one-cycle pulse on selected edge of oLEVEL
//  oEVENT       out  N    sticky edge flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (inRESET low, or iRESET_SYNC high at a clock edge): sync chain, filter counters,
//    oLEVEL, oEDGE, oEVENT all 0. iRESET_SYNC has priority over every other update.
//  - Sync: SYNC_STAGES flops per channel, no logic between them; s = last stage.
//  - Filter, per channel, counter cnt (4 bit):
//      s == oLEVEL            : cnt <= 0
//      s != oLEVEL, cnt<FILTER-1 : cnt <= cnt+1
//      s != oLEVEL, cnt==FILTER-1: oLEVEL <= s, cnt <= 0
//    A mismatch run shorter than FILTER samples is discarded (cnt returns to 0).
//  - Latency: iSIGNAL stable before clock edge 1 -> oLEVEL changes after edge SYNC_STAGES+FILTER.
//  - oEDGE registered, asserted exactly in the cycle oLEVEL takes its new value, for one
//    cycle; qualified by iMODE sampled at the updating edge: rise needs 0->1, fall 1->0,
//    both either, off never. Mode changes never create a pulse by themselves.
//  - Back-to-back toggles: minimum oLEVEL dwell is FILTER cycles; each accepted change pulses.
//  - Reset mid-filter: pending count lost; a line held high through reset release yields a
//    rise pulse SYNC_STAGES+FILTER cycles later (level starts at 0).
//  - All outputs registered; no combinational path from iSIGNAL to any output.
// CONFIGURATION
//  UART_EDGE_SYNC_STICKY_EN defined: oEVENT[i] sets on oEDGE[i] (registered, visible one
//    cycle after the pulse), held until iEVENT_CLR[i]; set and clear same cycle -> set wins.
//  Undefined: oEVENT tied to 0, iEVENT_CLR ignored; port list unchanged.
// STRUCTURE
//  - Package uart_edge_sync_pkg: mode constants EDGE_OFF/RISE/FALL/BOTH (2 bit), filter
//    counter width localparam (4).
//  - Sub-module uart_edge_sync_ch: one channel (sync chain, filter, edge qualify, sticky);
//    top instantiates N copies via generate and checks parameter legality at elaboration.
// TESTING
//  1 N=2,SYNC=2,FILTER=3, mode 01: ch0 0->1 held -> oLEVEL[0]=1 and oEDGE[0]=1 after edge 5, one cycle only.
//  2 FILTER=3: 2-cycle high glitch on ch1 -> oLEVEL/oEDGE never change; 3-cycle high -> accepted.
//  3 Mode 10 then 11 on ch0 toggling 0->1->0 -> mode 10: one pulse on fall only; mode 11: two pulses.
//  4 iRESET_SYNC pulsed while cnt=1 with line high -> all outputs 0 next cycle; rise pulse 5 cycles after release.
//  5 STICKY_EN: edge then iEVENT_CLR in same cycle as a second edge -> oEVENT stays 1; clear alone -> 0.
//  6 inRESET asserted async mid-run -> outputs 0 immediately, without clock.

Source files
------------

// File: rtl/uart_edge_sync_pkg.sv
// Shared constants for the multi-channel UART/SCI input conditioner:
// per-channel edge-mode encodings and the filter counter width.
package uart_edge_sync_pkg;
  localparam int CNT_W = 4;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
endpackage

// File: rtl/uart_edge_sync_ch.sv
// One conditioner channel: synchroniser, run-length glitch filter, mode-qualified
// edge pulse and optional sticky flag (UART_EDGE_SYNC_STICKY_EN).
module uart_edge_sync_ch
  import uart_edge_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1
) (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic       iRESET_SYNC,
  input  logic       iSIGNAL,
  input  logic [1:0] iMODE,
  input  logic       iEVENT_CLR,
  output logic       oLEVEL,
  output logic       oEDGE,
  output logic       oEVENT
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;
  logic                   accept;
  logic                   edge_ok;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != oLEVEL) && (cnt_q == LIM);

  // On an accepted change the new level equals s, so s alone tells the direction.
  always_comb begin
    edge_ok = 1'b0;
    case (iMODE)
      EDGE_RISE: edge_ok = s;
      EDGE_FALL: edge_ok = ~s;
      EDGE_BOTH: edge_ok = 1'b1;
      default:   edge_ok = 1'b0;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sync_q <= '0;
      cnt_q  <= '0;
      oLEVEL <= 1'b0;
      oEDGE  <= 1'b0;
    end else if (iRESET_SYNC) begin
      sync_q <= '0;
      cnt_q  <= '0;
      oLEVEL <= 1'b0;
      oEDGE  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iSIGNAL};
      oEDGE  <= accept & edge_ok;
      if (s == oLEVEL) begin
        cnt_q <= '0;
      end else if (accept) begin
        oLEVEL <= s;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef UART_EDGE_SYNC_STICKY_EN
  // Set takes priority so a clear coinciding with a new pulse never loses it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         oEVENT <= 1'b0;
    else if (iRESET_SYNC) oEVENT <= 1'b0;
    else if (oEDGE)       oEVENT <= 1'b1;
    else if (iEVENT_CLR)  oEVENT <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = iEVENT_CLR;
  assign oEVENT     = 1'b0;
`endif
endmodule

// File: rtl/uart_edge_sync.sv
// N-channel async-input conditioner: sync + glitch filter + selectable edge pulses.
// Sticky event flags are built only with UART_EDGE_SYNC_STICKY_EN defined.
module uart_edge_sync
  import uart_edge_sync_pkg::*;
#(
  parameter int N           = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1
) (
  input  logic           iCLOCK,
  input  logic           inRESET,
  input  logic           iRESET_SYNC,
  input  logic [N-1:0]   iSIGNAL,
  input  logic [2*N-1:0] iMODE,
  input  logic [N-1:0]   iEVENT_CLR,
  output logic [N-1:0]   oLEVEL,
  output logic [N-1:0]   oEDGE,
  output logic [N-1:0]   oEVENT
);
  generate
    if (N < 1)
      begin : g_bad_n $error("uart_edge_sync: N must be >= 1"); end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4)
      begin : g_bad_sync $error("uart_edge_sync: SYNC_STAGES must be 2..4"); end
    if (FILTER < 1 || FILTER > (1 << CNT_W) - 1)
      begin : g_bad_filter $error("uart_edge_sync: FILTER must be 1..15"); end
  endgenerate

  for (genvar i = 0; i < N; i++) begin : g_ch
    uart_edge_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER     (FILTER)
    ) u_ch (
      .iCLOCK     (iCLOCK),
      .inRESET    (inRESET),
      .iRESET_SYNC(iRESET_SYNC),
      .iSIGNAL    (iSIGNAL[i]),
      .iMODE      (iMODE[2*i+1:2*i]),
      .iEVENT_CLR (iEVENT_CLR[i]),
      .oLEVEL     (oLEVEL[i]),
      .oEDGE      (oEDGE[i]),
      .oEVENT     (oEVENT[i])
    );
  end
endmodule

// File: tb/tb_uart_edge_sync.sv
// Directed bench for uart_edge_sync, N=2, SYNC_STAGES=2, FILTER=3 (latency 5 edges).
// Sticky-flag expectations follow UART_EDGE_SYNC_STICKY_EN.
module tb_uart_edge_sync;
  localparam int N = 2;
`ifdef UART_EDGE_SYNC_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic           iCLOCK = 1'b0;
  logic           inRESET;
  logic           iRESET_SYNC;
  logic [N-1:0]   iSIGNAL;
  logic [2*N-1:0] iMODE;
  logic [N-1:0]   iEVENT_CLR;
  logic [N-1:0]   oLEVEL, oEDGE, oEVENT;

  int vectors     = 0;
  int miscompares = 0;

  uart_edge_sync #(.N(N), .SYNC_STAGES(2), .FILTER(3)) dut (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iRESET_SYNC(iRESET_SYNC),
    .iSIGNAL    (iSIGNAL),
    .iMODE      (iMODE),
    .iEVENT_CLR (iEVENT_CLR),
    .oLEVEL     (oLEVEL),
    .oEDGE      (oEDGE),
    .oEVENT     (oEVENT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLOCK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ev(input logic [N-1:0] x);
    return STICKY ? x : '0;
  endfunction

  // Drive a new line pattern and check the 5-edge acceptance plus one-cycle pulse.
  task automatic apply(input string tag, input logic [N-1:0] sig,
                       input logic [N-1:0] old_lvl, input logic [N-1:0] exp_edge);
    iSIGNAL = sig;
    tick(4);
    chk({tag, "_hold"}, oLEVEL, old_lvl);
    tick(1);
    chk({tag, "_lvl"}, oLEVEL, sig);
    chk({tag, "_edge"}, oEDGE, exp_edge);
    tick(1);
    chk({tag, "_edge_off"}, oEDGE, 2'b00);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    inRESET     = 1'b0;
    iRESET_SYNC = 1'b0;
    iSIGNAL     = '0;
    iMODE       = 4'b0101;
    iEVENT_CLR  = '0;
    tick(2);
    chk("rst_lvl", oLEVEL, 2'b00);
    chk("rst_edge", oEDGE, 2'b00);
    chk("rst_evt", oEVENT, 2'b00);
    inRESET = 1'b1;
    tick(3);
    chk("idle_lvl", oLEVEL, 2'b00);

    // 1: ch0 rise, accepted after edge 5, pulse for one cycle
    iSIGNAL = 2'b01;
    tick(4);
    chk("t1_e4_lvl", oLEVEL, 2'b00);
    tick(1);
    chk("t1_e5_lvl", oLEVEL, 2'b01);
    chk("t1_e5_edge", oEDGE, 2'b01);
    tick(1);
    chk("t1_e6_edge", oEDGE, 2'b00);
    chk("t1_e6_evt", oEVENT, ev(2'b01));

    // 2: 2-cycle glitch on ch1 rejected
    iSIGNAL = 2'b11;
    tick(2);
    iSIGNAL = 2'b01;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("t2_glitch_lvl", oLEVEL, 2'b01);
      chk("t2_glitch_edge", oEDGE, 2'b00);
    end
    // 3-cycle pulse accepted, then its fall is ignored in rise mode
    iSIGNAL = 2'b11;
    tick(3);
    iSIGNAL = 2'b01;
    tick(1);
    chk("t2_e4_lvl", oLEVEL, 2'b01);
    tick(1);
    chk("t2_e5_lvl", oLEVEL, 2'b11);
    chk("t2_e5_edge", oEDGE, 2'b10);
    tick(1);
    chk("t2_e6_edge", oEDGE, 2'b00);
    chk("t2_e6_evt", oEVENT, ev(2'b11));
    tick(1);
    chk("t2_e7_lvl", oLEVEL, 2'b11);
    tick(1);
    chk("t2_e8_lvl", oLEVEL, 2'b01);
    chk("t2_e8_edge", oEDGE, 2'b00);

    // 3: ch0 fall-only, then both
    iMODE = 4'b0110;
    apply("t3_fall_f", 2'b00, 2'b01, 2'b01);
    apply("t3_fall_r", 2'b01, 2'b00, 2'b00);
    iMODE = 4'b0111;
    apply("t3_both_f", 2'b00, 2'b01, 2'b01);
    apply("t3_both_r", 2'b01, 2'b00, 2'b01);
    apply("t3_both_f2", 2'b00, 2'b01, 2'b01);

    // 4: sync clear with cnt=1 and lines high
    iSIGNAL = 2'b11;
    tick(3);
    iRESET_SYNC = 1'b1;
    tick(1);
    chk("t4_clr_lvl", oLEVEL, 2'b00);
    chk("t4_clr_edge", oEDGE, 2'b00);
    chk("t4_clr_evt", oEVENT, 2'b00);
    iRESET_SYNC = 1'b0;
    tick(4);
    chk("t4_r4_lvl", oLEVEL, 2'b00);
    tick(1);
    chk("t4_r5_lvl", oLEVEL, 2'b11);
    chk("t4_r5_edge", oEDGE, 2'b11);
    tick(1);
    chk("t4_r6_edge", oEDGE, 2'b00);
    chk("t4_r6_evt", oEVENT, ev(2'b11));

    // 5: clear alone, then clear coinciding with a pulse
    iEVENT_CLR = 2'b11;
    tick(1);
    chk("t5_clr_evt", oEVENT, 2'b00);
    iEVENT_CLR = 2'b00;
    iSIGNAL    = 2'b10;
    tick(5);
    chk("t5_edge", oEDGE, 2'b01);
    chk("t5_lvl", oLEVEL, 2'b10);
    iEVENT_CLR = 2'b01;
    tick(1);
    chk("t5_setwins_evt", oEVENT, ev(2'b01));
    chk("t5_setwins_edge", oEDGE, 2'b00);
    tick(1);
    chk("t5_clr2_evt", oEVENT, 2'b00);
    iEVENT_CLR = 2'b00;

    // 6: async reset between edges, then ch1 held high through release
    #2;
    inRESET = 1'b0;
    #1;
    chk("t6_async_lvl", oLEVEL, 2'b00);
    chk("t6_async_edge", oEDGE, 2'b00);
    chk("t6_async_evt", oEVENT, 2'b00);
    #2;
    inRESET = 1'b1;
    tick(4);
    chk("t6_r4_lvl", oLEVEL, 2'b00);
    tick(1);
    chk("t6_r5_lvl", oLEVEL, 2'b10);
    chk("t6_r5_edge", oEDGE, 2'b10);
    tick(1);
    chk("t6_r6_edge", oEDGE, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
